// File: rtl/fir_mac_seq_if.sv
// Sample-in / result-out handshake bundle and coefficient write port of fir_mac_seq.
// The master side is the sample source and result sink. The slave side is the filter.
interface fir_mac_seq_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int ACC_W  = 18
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATA_W-1:0]    in_data;
  logic                        coef_we;
  logic [$clog2(TAPS)-1:0]     coef_addr;
  logic signed [COEF_W-1:0]    coef_wdata;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_W-1:0]     out_data;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_mac_seq.sv
// Sequential FIR engine: one shared multiplier walks all taps and produces one result per accepted sample.
// Define FIR_SAT_EN to make each accumulate step saturate. Without it, the accumulator wraps.
module fir_mac_seq #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int ACC_W  = 18
) (
  input logic           clk,
  input logic           rst,
  fir_mac_seq_if.slave  bus
);

  localparam int SEL_W  = $clog2(TAPS);
  localparam int LEAVES = 1 << SEL_W;
  localparam int PW     = DATA_W + COEF_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [SEL_W-1:0]       LAST_IDX = SEL_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Binary 2:1 mux tree. Level 0 uses sel[0] to pair adjacent leaves, and each later level halves the set.
  function automatic logic [PW-1:0] mux_tree(input logic [LEAVES-1:0][PW-1:0] leaves,
                                             input logic [SEL_W-1:0]          sel);
    logic [LEAVES-1:0][PW-1:0] v;
    v = leaves;
    for (int lvl = 0; lvl < SEL_W; lvl++) begin
      for (int j = 0; j < (LEAVES >> (lvl + 1)); j++) begin
        v[j] = sel[lvl] ? v[2*j+1] : v[2*j];
      end
    end
    return v[0];
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
`ifdef FIR_SAT_EN
    logic signed [ACC_W:0] wide;
    wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      return wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      return wide[ACC_W-1:0];
    end
`else
    return a + b;
`endif
  endfunction

  logic [1:0]               state_q, state_d;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] x_d [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic signed [COEF_W-1:0] c_d [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [SEL_W-1:0]         idx_q, idx_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  out_data_q, out_data_d;

  logic [LEAVES-1:0][PW-1:0] leaves_s;
  logic [PW-1:0]             pair_s;
  logic signed [DATA_W-1:0]  x_sel_s;
  logic signed [COEF_W-1:0]  c_sel_s;
  logic signed [PW-1:0]      prod_s;
  logic signed [ACC_W-1:0]   prod_ext_s;
  logic signed [ACC_W-1:0]   acc_sum_s;

  // Tree leaves beyond TAPS are tied to zero. They are never selected.
  genvar gi;
  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < TAPS) begin : g_used
        assign leaves_s[gi] = {x_q[gi], c_q[gi]};
      end else begin : g_pad
        assign leaves_s[gi] = '0;
      end
    end
  endgenerate

  assign pair_s     = mux_tree(leaves_s, idx_q);
  assign x_sel_s    = pair_s[PW-1:COEF_W];
  assign c_sel_s    = pair_s[COEF_W-1:0];
  assign prod_s     = PW'(x_sel_s) * PW'(c_sel_s);
  assign prod_ext_s = ACC_W'(prod_s);
  assign acc_sum_s  = acc_add(acc_q, prod_ext_s);

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Next-state logic for the FSM, delay line, coefficient bank and accumulator.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        out_valid_d = 1'b0;
        if (bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
          c_d[bus.coef_addr] = bus.coef_wdata;
        end else begin
          c_d = c_q;
        end
        if (bus.in_valid) begin
          x_d[0] = bus.in_data;
          for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        acc_d = acc_sum_s;
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = acc_sum_s;
          state_d     = S_OUT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_MAC;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State registers. Reset clears the data path, the taps and the coefficients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= x_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed and random bench for fir_mac_seq. Expected results come from a plain dot-product model of the filter.
module tb_fir_mac_seq;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 4;
  localparam int ACC_W  = 16;
  localparam int AW     = $clog2(TAPS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_mac_seq_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W)) bus ();

  fir_mac_seq #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int xm [TAPS];
  int cm [TAPS];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      xm[k] = 0;
      cm[k] = 0;
    end
  endtask

  task automatic model_accept(input int d);
    for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = d;
  endtask

  // Filter output: the taps are summed in index order and then wrapped or clamped to ACC_W bits.
  function automatic logic signed [ACC_W-1:0] expect_out();
    longint s, hi, lo;
    hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo = -(longint'(1) <<< (ACC_W - 1));
    s = 0;
    for (int k = 0; k < TAPS; k++) begin
      s += longint'(xm[k]) * longint'(cm[k]);
`ifdef FIR_SAT_EN
      if (s > hi) s = hi;
      if (s < lo) s = lo;
`endif
    end
    return ACC_W'(s);
  endfunction

  task automatic write_coef(input int a, input int v);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(a);
    bus.coef_wdata = COEF_W'(v);
    tick();
    bus.coef_we = 1'b0;
    cm[a] = v;
  endtask

  // wr_mode 0: no write. 1: the coefficient write happens on the accept edge. 2: the write is attempted during MAC.
  task automatic do_sample(input int d, input int hold, input int wr_mode, input int wr_addr, input int wr_val);
    int n;
    logic signed [ACC_W-1:0] exp;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(d);
    if (wr_mode == 1) begin
      bus.coef_we    = 1'b1;
      bus.coef_addr  = AW'(wr_addr);
      bus.coef_wdata = COEF_W'(wr_val);
      cm[wr_addr]    = wr_val;
    end
    model_accept(d);
    exp = expect_out();
    tick();
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    n = 0;
    if (wr_mode == 2) begin
      bus.coef_we    = 1'b1;
      bus.coef_addr  = AW'(wr_addr);
      bus.coef_wdata = COEF_W'(wr_val);
      tick();
      bus.coef_we = 1'b0;
      n = 1;
    end
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", n, TAPS);
    check("out_data", bus.out_data, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_data", bus.out_data, exp);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 0);
    check("back_to_idle", bus.in_ready, 1);
  endtask

  initial begin
    int b2b_exp [5];
    int got, last_cyc, r;
    b2b_exp = '{1, 2, 3, 4, 4};

    rst = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    bus.out_ready  = 1'b0;
    model_clear();
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Impulse response. The first result is also held under backpressure.
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    do_sample(1, 5, 0, 0, 0);
    do_sample(0, 0, 0, 0, 0);
    do_sample(0, 0, 0, 0, 0);
    do_sample(0, 0, 0, 0, 0);

    // Negative full scale: the last result wraps to 0, or clamps to the maximum when saturating.
    for (int k = 0; k < TAPS; k++) write_coef(k, -128);
    for (int i = 0; i < TAPS; i++) do_sample(-128, 0, 0, 0, 0);

    // A coefficient write during MAC is ignored. The same write on the accept edge is used.
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    do_sample(1, 0, 2, 2, 5);
    do_sample(0, 0, 1, 2, 5);
    do_sample(3, 1, 0, 0, 0);

    // Reset asserted in the second MAC cycle.
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    model_clear();
    tick();
    rst = 1'b0;
    write_coef(0, 7);
    write_coef(1, 2);
    write_coef(2, 3);
    write_coef(3, 4);
    do_sample(1, 0, 0, 0, 0);

    // Random samples, coefficient updates and backpressure.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)) - 128);
      r = int'($urandom_range(0, 2));
      do_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)), r,
                int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)) - 128);
    end

    // Back-to-back with in_valid and out_ready held high.
    rst = 1'b1;
    #1;
    model_clear();
    tick();
    rst = 1'b0;
    for (int k = 0; k < TAPS; k++) write_coef(k, 1);
    bus.in_valid  = 1'b1;
    bus.in_data   = DATA_W'(1);
    bus.out_ready = 1'b1;
    got = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 60 && got < 5; cyc++) begin
      tick();
      if (bus.out_valid) begin
        check("b2b_data", bus.out_data, b2b_exp[got]);
        if (got > 0) check("b2b_period", cyc - last_cyc, TAPS + 2);
        last_cyc = cyc;
        got++;
      end
    end
    check("b2b_count", got, 5);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
- Sequential FIR multiply-accumulate engine: keeps the tap delay line and coefficient bank, and computes one output per accepted input sample.
- Time-multiplexes a single multiplier across all taps. The tap select drives the bit-level 2:1 mux tree that picks the sample/coefficient pair each cycle.
- Sits between the sample source (valid/ready in) and the filter output sink (valid/ready out).

Parameters:
DATA_W, 8, signed input sample width
COEF_W, 8, signed coefficient width
TAPS, 4, number of filter taps (>=2)
ACC_W, 18, signed accumulator/output width (default = DATA_W+COEF_W+clog2(TAPS))

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DATA_W  signed input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  coefficient index
coef_wdata  in  COEF_W  signed coefficient value
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
out_data  out  ACC_W  signed filter result

Behaviour:
- Reset (async, active-high): state=IDLE, delay line x[0..TAPS-1]=0, coefficients c[0..TAPS-1]=0, acc=0, idx=0, out_valid=0, out_data=0. in_ready=0 while rst is high.
- States: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On edge with in_valid=1: x[0]<=in_data, x[k]<=x[k-1] for k=1..TAPS-1, acc<=0, idx<=0, go MAC.
- MAC:
  - in_ready=0.
  - Each edge: acc<=acc+sext(x[idx]*c[idx]), idx<=idx+1.
  - On the edge where idx==TAPS-1: go OUT (that edge's product is included).
- OUT:
  - out_valid=1; out_data=acc, held stable until the handshake.
  - On edge with out_ready=1: go IDLE, out_valid<=0.
  - out_valid never drops without out_ready.
- Latency: out_valid rises exactly TAPS edges after the input-accept edge.
- Minimum sample period: TAPS+2 cycles (out_ready tied high).
- Arithmetic: two's complement. Product is DATA_W+COEF_W bits, sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W.
- Coefficient writes:
  - Take effect only in IDLE: c[coef_addr]<=coef_wdata on the edge.
  - Ignored in MAC and OUT.
  - A write and a sample accept on the same IDLE edge both take effect; the following MAC pass uses the new coefficient.
- Reset asserted mid-MAC or in OUT: immediate return to reset values. The partial result is discarded, and the delay line and coefficients are cleared.
- in_valid held high in MAC/OUT: no sample is consumed, and the delay line does not shift.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined: each accumulate saturates to the signed ACC_W range, 2^(ACC_W-1)-1 or -2^(ACC_W-1). Once the accumulator is saturated, it stays saturated only as long as subsequent additions keep pushing in the same direction.
- Undefined: plain wrap-around accumulation.

Test Plan:
- Impulse: coefs 1,2,3,4; inputs 1,0,0,0 -> out_data 1,2,3,4. Each out_valid arrives 4 edges after its accept.
- Backpressure: out_ready low 5 cycles in OUT -> out_valid=1, out_data stable, in_ready=0 throughout; out_ready high -> IDLE next edge.
- Negative full-scale with ACC_W=16: coefs all -128, four inputs of -128 -> fourth output wraps to 0. With FIR_SAT_EN it is 32767.
- Coefficient write in MAC: set c[2]=5 mid-pass -> ignored; result uses the old c[2]. The same write in IDLE affects the next pass.
- Reset mid-MAC: assert rst on the 2nd MAC cycle -> out_valid=0 and out_data=0 immediately. After release, impulse 1 with coefs reloaded gives c[0].
- Back-to-back: in_valid and out_ready held high, steady input 1, coefs 1,1,1,1 -> outputs 1,2,3,4,4 at a 6-cycle period.
